wakeup_issue_queue: RTL

Out-of-order issue queue between dispatch and one execution unit (adder, logCmp, shift or jal class) in the crackCore backend.
- Accepts renamed micro-ops from dispatch.
- Tracks source-operand readiness by snooping writeback physical-register tags.
- Each cycle, issues the oldest entry whose sources are both ready to the execution-parameter register.
- Replaces the plain issue_buffer wherever wakeup-driven selection is needed.

---
 rtl/wakeup_issue_queue_pkg.sv | 27 ++
 rtl/wakeup_issue_queue_if.sv | 42 ++++
 rtl/wakeup_issue_queue_entry.sv | 116 +++++++++++
 rtl/wakeup_issue_queue.sv | 133 +++++++++++++
 4 files changed

// File: rtl/wakeup_issue_queue_pkg.sv
// Shared constants and types for the wakeup-driven issue queue: tag width,
// per-unit default depths and the per-entry update operation.
package wakeup_issue_queue_pkg;

  localparam int DW_DEFAULT         = 64;
  localparam int TW_DEFAULT         = 6;
  localparam int WB_PORTS           = 2;
  localparam int ADDER_ISSUE_DEPTH  = 8;
  localparam int LOGCMP_ISSUE_DEPTH = 8;
  localparam int SHIFT_ISSUE_DEPTH  = 4;
  localparam int JAL_ISSUE_DEPTH    = 4;

  typedef logic [TW_DEFAULT-1:0] phy_tag_t;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } entry_op_e;

  // Width of an index into a queue of the given depth (at least 1 bit).
  function automatic int sel_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wakeup_issue_queue_if.sv
// Dispatch / writeback / issue bundle of the issue queue. The master side is
// the surrounding pipeline, the slave side is the queue itself.
interface wakeup_issue_queue_if
  import wakeup_issue_queue_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int DP     = ADDER_ISSUE_DEPTH,
  parameter int TW     = TW_DEFAULT,
  parameter int WB_NUM = WB_PORTS
);
  localparam int CW = $clog2(DP + 1);

  logic                 flush;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [DW-1:0]        disp_payload;
  logic [TW-1:0]        disp_rs1_tag;
  logic                 disp_rs1_rdy;
  logic [TW-1:0]        disp_rs2_tag;
  logic                 disp_rs2_rdy;
  logic [WB_NUM-1:0]    wb_valid;
  logic [WB_NUM*TW-1:0] wb_tag;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [DW-1:0]        iss_payload;
  logic [TW-1:0]        iss_rs1_tag;
  logic [TW-1:0]        iss_rs2_tag;
  logic [CW-1:0]        count;

  modport master (
    output flush, disp_valid, disp_payload, disp_rs1_tag, disp_rs1_rdy,
           disp_rs2_tag, disp_rs2_rdy, wb_valid, wb_tag, iss_ready,
    input  disp_ready, iss_valid, iss_payload, iss_rs1_tag, iss_rs2_tag, count
  );

  modport slave (
    input  flush, disp_valid, disp_payload, disp_rs1_tag, disp_rs1_rdy,
           disp_rs2_tag, disp_rs2_rdy, wb_valid, wb_tag, iss_ready,
    output disp_ready, iss_valid, iss_payload, iss_rs1_tag, iss_rs2_tag, count
  );

endinterface

// File: rtl/wakeup_issue_queue_entry.sv
// One issue-queue slot: holds, shifts down from its upper neighbour, loads from
// dispatch or clears; writeback wakeup is applied to whichever source is chosen.
module wakeup_issue_queue_entry
  import wakeup_issue_queue_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int TW     = TW_DEFAULT,
  parameter int WB_NUM = WB_PORTS
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  entry_op_e            op,
  input  logic [DW-1:0]        up_payload,
  input  logic [TW-1:0]        up_rs1_tag,
  input  logic                 up_rs1_rdy,
  input  logic [TW-1:0]        up_rs2_tag,
  input  logic                 up_rs2_rdy,
  input  logic [DW-1:0]        disp_payload,
  input  logic [TW-1:0]        disp_rs1_tag,
  input  logic                 disp_rs1_rdy,
  input  logic [TW-1:0]        disp_rs2_tag,
  input  logic                 disp_rs2_rdy,
  input  logic [WB_NUM-1:0]    wb_valid,
  input  logic [WB_NUM*TW-1:0] wb_tag,
  output logic                 valid,
  output logic [DW-1:0]        payload,
  output logic [TW-1:0]        rs1_tag,
  output logic                 rs1_rdy,
  output logic [TW-1:0]        rs2_tag,
  output logic                 rs2_rdy
);

  logic          valid_q, valid_d;
  logic [DW-1:0] payload_q, payload_d;
  logic [TW-1:0] rs1_tag_q, rs1_tag_d;
  logic          rs1_rdy_q, rs1_rdy_d;
  logic [TW-1:0] rs2_tag_q, rs2_tag_d;
  logic          rs2_rdy_q, rs2_rdy_d;

  logic [DW-1:0]     src_payload;
  logic [TW-1:0]     src_rs1_tag, src_rs2_tag;
  logic              src_rs1_rdy, src_rs2_rdy;
  logic [WB_NUM-1:0] hit1, hit2;

  always_comb begin
    src_payload = payload_q;
    src_rs1_tag = rs1_tag_q;
    src_rs1_rdy = rs1_rdy_q;
    src_rs2_tag = rs2_tag_q;
    src_rs2_rdy = rs2_rdy_q;
    valid_d     = valid_q;
    case (op)
      OP_SHIFT: begin
        src_payload = up_payload;
        src_rs1_tag = up_rs1_tag;
        src_rs1_rdy = up_rs1_rdy;
        src_rs2_tag = up_rs2_tag;
        src_rs2_rdy = up_rs2_rdy;
        valid_d     = 1'b1;
      end
      OP_LOAD: begin
        src_payload = disp_payload;
        src_rs1_tag = disp_rs1_tag;
        src_rs1_rdy = disp_rs1_rdy;
        src_rs2_tag = disp_rs2_tag;
        src_rs2_rdy = disp_rs2_rdy;
        valid_d     = 1'b1;
      end
      OP_CLEAR: valid_d = 1'b0;
      default:  valid_d = valid_q;
    endcase
  end

  // Comparing against the chosen source covers held, shifting and bypassed pushes alike.
  genvar gi;
  generate
    for (gi = 0; gi < WB_NUM; gi++) begin : g_wake
      assign hit1[gi] = wb_valid[gi] && (src_rs1_tag == wb_tag[gi*TW +: TW]);
      assign hit2[gi] = wb_valid[gi] && (src_rs2_tag == wb_tag[gi*TW +: TW]);
    end
  endgenerate

  always_comb begin
    payload_d = src_payload;
    rs1_tag_d = src_rs1_tag;
    rs2_tag_d = src_rs2_tag;
    rs1_rdy_d = src_rs1_rdy | (|hit1);
    rs2_rdy_d = src_rs2_rdy | (|hit2);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      rs1_tag_q <= '0;
      rs1_rdy_q <= 1'b0;
      rs2_tag_q <= '0;
      rs2_rdy_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      rs1_tag_q <= rs1_tag_d;
      rs1_rdy_q <= rs1_rdy_d;
      rs2_tag_q <= rs2_tag_d;
      rs2_rdy_q <= rs2_rdy_d;
    end
  end

  assign valid   = valid_q;
  assign payload = payload_q;
  assign rs1_tag = rs1_tag_q;
  assign rs1_rdy = rs1_rdy_q;
  assign rs2_tag = rs2_tag_q;
  assign rs2_rdy = rs2_rdy_q;

endmodule

// File: rtl/wakeup_issue_queue.sv
// Compacting out-of-order issue queue: oldest-ready select, shift-down on
// issue, append on dispatch, tag wakeup from the writeback ports.
module wakeup_issue_queue
  import wakeup_issue_queue_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int DP     = ADDER_ISSUE_DEPTH,
  parameter int TW     = TW_DEFAULT,
  parameter int WB_NUM = WB_PORTS
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  wakeup_issue_queue_if.slave  bus
);

  localparam int CW = $clog2(DP + 1);
  localparam int SW = sel_width(DP);

  logic [CW-1:0] count_q, count_d;

  // One extra all-zero slot above the top so every entry has an upper neighbour.
  logic          e_valid   [DP];
  logic [DW-1:0] e_payload [DP+1];
  logic [TW-1:0] e_rs1_tag [DP+1];
  logic          e_rs1_rdy [DP+1];
  logic [TW-1:0] e_rs2_tag [DP+1];
  logic          e_rs2_rdy [DP+1];
  entry_op_e     e_op      [DP];

  logic          sel_found;
  logic [SW-1:0] sel_idx;
  logic [CW-1:0] sel_ext;
  logic          disp_ready_w;
  logic          iss_valid_w;
  logic          issue_fire;
  logic          push_fire;
  logic [CW-1:0] push_idx;

  assign e_payload[DP] = '0;
  assign e_rs1_tag[DP] = '0;
  assign e_rs1_rdy[DP] = 1'b0;
  assign e_rs2_tag[DP] = '0;
  assign e_rs2_rdy[DP] = 1'b0;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DP - 1; i >= 0; i--) begin
      if (e_valid[i] && e_rs1_rdy[i] && e_rs2_rdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = SW'(i);
      end
    end
  end

  assign sel_ext      = CW'(sel_idx);
  assign disp_ready_w = (count_q < CW'(DP));
  assign iss_valid_w  = sel_found && !bus.flush;
  assign issue_fire   = iss_valid_w && bus.iss_ready;
  assign push_fire    = bus.disp_valid && disp_ready_w;
  assign push_idx     = issue_fire ? (count_q - CW'(1)) : count_q;

  always_comb begin
    for (int i = 0; i < DP; i++) begin
      e_op[i] = OP_HOLD;
      if (bus.flush) begin
        e_op[i] = OP_CLEAR;
      end else if (push_fire && (push_idx == CW'(i))) begin
        e_op[i] = OP_LOAD;
      end else if (issue_fire && (CW'(i) >= sel_ext) && (CW'(i + 1) < count_q)) begin
        e_op[i] = OP_SHIFT;
      end else if (issue_fire && (CW'(i + 1) == count_q)) begin
        e_op[i] = OP_CLEAR;
      end
    end
  end

  always_comb begin
    count_d = count_q + CW'(push_fire) - CW'(issue_fire);
    if (bus.flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DP; gi++) begin : g_entry
      wakeup_issue_queue_entry #(
        .DW     (DW),
        .TW     (TW),
        .WB_NUM (WB_NUM)
      ) u_entry (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .op           (e_op[gi]),
        .up_payload   (e_payload[gi+1]),
        .up_rs1_tag   (e_rs1_tag[gi+1]),
        .up_rs1_rdy   (e_rs1_rdy[gi+1]),
        .up_rs2_tag   (e_rs2_tag[gi+1]),
        .up_rs2_rdy   (e_rs2_rdy[gi+1]),
        .disp_payload (bus.disp_payload),
        .disp_rs1_tag (bus.disp_rs1_tag),
        .disp_rs1_rdy (bus.disp_rs1_rdy),
        .disp_rs2_tag (bus.disp_rs2_tag),
        .disp_rs2_rdy (bus.disp_rs2_rdy),
        .wb_valid     (bus.wb_valid),
        .wb_tag       (bus.wb_tag),
        .valid        (e_valid[gi]),
        .payload      (e_payload[gi]),
        .rs1_tag      (e_rs1_tag[gi]),
        .rs1_rdy      (e_rs1_rdy[gi]),
        .rs2_tag      (e_rs2_tag[gi]),
        .rs2_rdy      (e_rs2_rdy[gi])
      );
    end
  endgenerate

  assign bus.disp_ready  = disp_ready_w;
  assign bus.iss_valid   = iss_valid_w;
  assign bus.iss_payload = sel_found ? e_payload[sel_idx] : '0;
  assign bus.iss_rs1_tag = sel_found ? e_rs1_tag[sel_idx] : '0;
  assign bus.iss_rs2_tag = sel_found ? e_rs2_tag[sel_idx] : '0;
  assign bus.count       = count_q;

endmodule
